mem_bus_initiator: RTL and testbench

Initiator (master) end of the internal memory request/done bus. Accepts single read/write commands from a CPU-side port, drives `read_q`/`write_q`, `addr_out` and `data_out` toward a memory responder, and waits for the matching `read_dn`/`write_dn`. Returns read data or an error flag on a one-cycle response strobe. It sits between a CPU core's load/store unit and any memory responder on the shared bus. It supports halt-and-retry on `rw_halt` and a bounded-wait timeout.

---
 rtl/mem_bus_initiator_pkg.sv | 30 +++
 rtl/mem_bus_initiator.sv | 188 ++++++++++++++++++
 tb/tb_mem_bus_initiator.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_initiator_pkg
// Shared definitions for the memory request/done bus initiator:
//   - default address/data widths (ADDR_SIZE0 / DATA_SIZE0 are MSB indices)
//   - default WAIT timeout in cycles
//   - initiator state encoding
//   - helper that selects the done strobe matching the pending operation
// -----------------------------------------------------------------------------
package mem_bus_initiator_pkg;

  localparam int ADDR_SIZE0       = 15;
  localparam int DATA_SIZE0       = 31;
  localparam int MEM_INIT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    MEM_INIT_IDLE  = 3'd0,
    MEM_INIT_ISSUE = 3'd1,
    MEM_INIT_WAIT  = 3'd2,
    MEM_INIT_HALT  = 3'd3,
    MEM_INIT_RESP  = 3'd4
  } mem_init_state_t;

  // Only the done strobe of the pending operation type may complete it.
  function automatic logic op_done(input logic op_write,
                                   input logic read_dn,
                                   input logic write_dn);
    return op_write ? write_dn : read_dn;
  endfunction

endpackage

// File: rtl/mem_bus_initiator.sv
// -----------------------------------------------------------------------------
// mem_bus_initiator
// Initiator end of the memory request/done bus. Takes one read/write command
// at a time from the CPU side, drives read_q/write_q with addr_out/data_out
// to a responder, waits for the matching done (type and echoed address), and
// returns a one-cycle rsp_valid strobe carrying read data or a timeout error.
// rw_halt aborts the bus request and the command is re-issued once the halt
// clears.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid/write/addr/data  CPU command; accepted when req_valid & req_ready
//   req_ready                  combinational: IDLE, out of reset, bus not halted
//   rsp_valid/data/err         one-cycle completion strobe, read data, timeout
//   read_q/write_q             bus requests (never both high)
//   addr_out/data_out          bus address / write data, 0 when not requesting
//   data_in/addr_in            responder read data / echoed address
//   read_dn/write_dn           responder done strobes
//   rw_halt                    bus halt
// All outputs except req_ready are registered.
// -----------------------------------------------------------------------------
module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter int ADDR_W  = ADDR_SIZE0 + 1,
  parameter int DATA_W  = DATA_SIZE0 + 1,
  parameter int TIMEOUT = MEM_INIT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              read_q,
  output logic              write_q,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              read_dn,
  input  logic              write_dn,
  input  logic              rw_halt
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  mem_init_state_t   state_r, state_nx_s;
  logic              op_r, op_nx_s;          // 1 = write
  logic [ADDR_W-1:0] addr_r, addr_nx_s;
  logic [DATA_W-1:0] wdata_r, wdata_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;

  // Bus drive request for the next cycle and the command it carries.
  logic              drive_s;
  logic              drv_op_s;
  logic [ADDR_W-1:0] drv_addr_s;
  logic [DATA_W-1:0] drv_wdata_s;

  logic              rsp_valid_nx_s;
  logic [DATA_W-1:0] rsp_data_nx_s;
  logic              rsp_err_nx_s;
  logic              done_s;
  logic              timeout_s;

  assign req_ready = rst && (state_r == MEM_INIT_IDLE) && !rw_halt;

  assign done_s = op_done(op_r, read_dn, write_dn) && (addr_in == addr_r);

  // The counter holds the number of completed WAIT cycles minus one at each
  // edge, so matching TIMEOUT-1 aborts exactly TIMEOUT edges after WAIT entry.
  assign timeout_s = (TIMEOUT != 0) && (cnt_r == CNT_W'(TIMEOUT - 1));

  // Next-state, latched command, counter and next registered outputs.
  always_comb begin
    state_nx_s     = state_r;
    op_nx_s        = op_r;
    addr_nx_s      = addr_r;
    wdata_nx_s     = wdata_r;
    cnt_nx_s       = cnt_r;
    drive_s        = 1'b0;
    drv_op_s       = op_r;
    drv_addr_s     = addr_r;
    drv_wdata_s    = wdata_r;
    rsp_valid_nx_s = 1'b0;
    rsp_data_nx_s  = '0;
    rsp_err_nx_s   = 1'b0;

    case (state_r)
      MEM_INIT_IDLE: begin
        if (req_valid && req_ready) begin
          op_nx_s     = req_write;
          addr_nx_s   = req_addr;
          wdata_nx_s  = req_data;
          state_nx_s  = MEM_INIT_ISSUE;
          drive_s     = 1'b1;
          drv_op_s    = req_write;
          drv_addr_s  = req_addr;
          drv_wdata_s = req_data;
        end else begin
          state_nx_s = MEM_INIT_IDLE;
        end
      end

      MEM_INIT_ISSUE: begin
        if (rw_halt) begin
          state_nx_s = MEM_INIT_HALT;
        end else begin
          state_nx_s = MEM_INIT_WAIT;
          cnt_nx_s   = '0;
          drive_s    = 1'b1;
        end
      end

      MEM_INIT_WAIT: begin
        // Completion wins over a halt or timeout seen at the same edge.
        if (done_s) begin
          state_nx_s     = MEM_INIT_RESP;
          rsp_valid_nx_s = 1'b1;
          rsp_data_nx_s  = op_r ? '0 : data_in;
        end else if (rw_halt) begin
          state_nx_s = MEM_INIT_HALT;
        end else if (timeout_s) begin
          state_nx_s     = MEM_INIT_RESP;
          rsp_valid_nx_s = 1'b1;
          rsp_err_nx_s   = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
          drive_s  = 1'b1;
        end
      end

      MEM_INIT_HALT: begin
        if (!rw_halt) begin
          state_nx_s = MEM_INIT_ISSUE;
          drive_s    = 1'b1;
        end else begin
          state_nx_s = MEM_INIT_HALT;
        end
      end

      MEM_INIT_RESP: begin
        state_nx_s = MEM_INIT_IDLE;
      end

      default: begin
        state_nx_s = MEM_INIT_IDLE;
      end
    endcase
  end

  // State, command latch, counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= MEM_INIT_IDLE;
      op_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      cnt_r     <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_out  <= '0;
      data_out  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      op_r      <= op_nx_s;
      addr_r    <= addr_nx_s;
      wdata_r   <= wdata_nx_s;
      cnt_r     <= cnt_nx_s;
      // Address and data are zeroed whenever no request is driven.
      read_q    <= drive_s && !drv_op_s;
      write_q   <= drive_s && drv_op_s;
      addr_out  <= drive_s ? drv_addr_s : '0;
      data_out  <= (drive_s && drv_op_s) ? drv_wdata_s : '0;
      rsp_valid <= rsp_valid_nx_s;
      rsp_data  <= rsp_data_nx_s;
      rsp_err   <= rsp_err_nx_s;
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
`timescale 1ns/1ps
// Bench for mem_bus_initiator: a command driver that also plays the bus
// responder, a reference memory updated from the CPU-side commands, and a
// monitor that compares every rsp_valid strobe against a queue of expected
// responses and polices the idle-bus rules on every cycle.
module tb_mem_bus_initiator;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready, rsp_valid, rsp_err, read_q, write_q;
  logic [DW-1:0] rsp_data, data_out;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] addr_in = '0;
  logic          read_dn = 1'b0, write_dn = 1'b0, rw_halt = 1'b0;

  mem_bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .read_q(read_q), .write_q(write_q), .addr_out(addr_out), .data_out(data_out),
    .data_in(data_in), .addr_in(addr_in), .read_dn(read_dn), .write_dn(write_dn),
    .rw_halt(rw_halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  rsp_t          exp_q[$];
  rsp_t          mon_e;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];  // what the CPU should observe
  logic [DW-1:0] bus_mem [logic [AW-1:0]];  // what the responder stores
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(a) - 32'd1;
  endfunction

  function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] rd_bus(input logic [AW-1:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_active(input string tag, input bit wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, "_read_q"},   64'(read_q),   64'(!wr));
    chk({tag, "_write_q"},  64'(write_q),  64'(wr));
    chk({tag, "_addr_out"}, 64'(addr_out), 64'(a));
    chk({tag, "_data_out"}, 64'(data_out), wr ? 64'(d) : 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp"},       64'({rsp_valid, rsp_err, rsp_data}), 64'd0);
    chk({tag, "_bus"},       64'({read_q, write_q, addr_out, data_out}), 64'd0);
  endtask

  // Monitor: scoreboard compare on each response plus idle-bus rules.
  always @(negedge clk) begin
    if (rst) begin
      chk("bus_one_hot", 64'(read_q & write_q), 64'd0);
      chk("addr_idle", (read_q || write_q) ? 64'd0 : 64'(addr_out), 64'd0);
      chk("data_idle", write_q ? 64'd0 : 64'(data_out), 64'd0);
      if (rsp_valid) begin
        chk("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
          chk("rsp_err",  64'(rsp_err),  64'(mon_e.err));
        end
      end
    end
  end

  // mode: 0 normal, 1 done with wrong address first, 4 done of wrong type first,
  //       2 four-cycle halt during WAIT, 3 no done (timeout).
  // Called and returns just after a negedge, with the DUT idle.
  task automatic run_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int mode, input int extra);
    rsp_t e;
    e.err  = (mode == 3);
    e.data = '0;
    if (mode != 3) begin
      if (wr) ref_mem[a] = d;
      else    e.data = rd_ref(a);
    end
    exp_q.push_back(e);

    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
    @(negedge clk);  // accept edge T
    req_valid = 1'b0; req_addr = AW'($urandom); req_data = $urandom;
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    check_active("issue", wr, a, d);
    @(negedge clk);  // WAIT from T+1
    check_active("wait", wr, a, d);

    case (mode)
      1, 4: begin
        if (mode == 1) begin
          if (wr) write_dn = 1'b1; else read_dn = 1'b1;
          addr_in = a + 16'd1;
        end else begin
          if (wr) read_dn = 1'b1; else write_dn = 1'b1;
          addr_in = a;
        end
        data_in = $urandom;
        @(negedge clk);
        read_dn = 1'b0; write_dn = 1'b0;
        chk("no_rsp_bad_done", 64'(rsp_valid), 64'd0);
        check_active("bad_done", wr, a, d);
      end
      2: begin
        rw_halt = 1'b1;
        @(negedge clk);
        chk("halt_q_low", 64'({read_q, write_q}), 64'd0);
        chk("halt_addr_low", 64'(addr_out), 64'd0);
        chk("halt_ready", 64'(req_ready), 64'd0);
        repeat (3) @(negedge clk);
        rw_halt = 1'b0;
        @(negedge clk);
        check_active("reissue", wr, a, d);
        @(negedge clk);
        check_active("rewait", wr, a, d);
      end
      3: begin
        repeat (TO - 1) begin
          @(negedge clk);
          chk("no_rsp_before_timeout", 64'(rsp_valid), 64'd0);
        end
        @(negedge clk);  // edge T+1+TO
        chk("timeout_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("timeout_q_low", 64'({read_q, write_q}), 64'd0);
        @(negedge clk);
        chk("timeout_ready_back", 64'(req_ready), 64'd1);
        chk("timeout_rsp_one_cycle", 64'(rsp_valid), 64'd0);
        return;
      end
      default: ;
    endcase

    repeat (extra) begin
      @(negedge clk);
      check_active("hold", wr, a, d);
      chk("no_rsp_hold", 64'(rsp_valid), 64'd0);
    end
    // Responder acts on what the DUT actually drives.
    addr_in = addr_out;
    if (wr) begin
      bus_mem[addr_out] = data_out;
      write_dn = 1'b1;
    end else begin
      data_in = rd_bus(addr_out);
      read_dn = 1'b1;
    end
    @(negedge clk);
    read_dn = 1'b0; write_dn = 1'b0;
    addr_in = AW'($urandom); data_in = $urandom;
    chk("rsp_valid_on_done", 64'(rsp_valid), 64'd1);
    chk("q_low_on_rsp", 64'({read_q, write_q}), 64'd0);
    @(negedge clk);
    chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    chk("ready_after_rsp", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int  m;
    bit  wr;
    // Reset state.
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);
    rw_halt = 1'b1; #1;
    chk("ready_blocked_by_halt", 64'(req_ready), 64'd0);
    rw_halt = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_cmd(1'b0, 16'h0011, 32'h0, 0, 0);          // read 0x11 -> 0x10
    run_cmd(1'b1, 16'h0005, 32'h0000_00AB, 0, 2);  // write 0x05 = 0xAB
    run_cmd(1'b0, 16'h0011, 32'h0, 1, 1);          // wrong-address done first
    run_cmd(1'b0, 16'h0011, 32'h0, 2, 0);          // halt/retry
    run_cmd(1'b0, 16'h0021, 32'h0, 3, 0);          // timeout
    run_cmd(1'b0, 16'h0005, 32'h0, 4, 0);          // wrong-type done, reads 0xAB

    // Reset while waiting.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0033;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_outputs_zero("reset_mid_wait");
    @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", 64'(req_ready), 64'd1);
    chk("no_bus_after_mid_reset", 64'({read_q, write_q}), 64'd0);
    run_cmd(1'b0, 16'h0033, 32'h0, 0, 1);

    // Randomized traffic over a small address range so reads hit writes.
    for (int i = 0; i < 40; i++) begin
      m  = $urandom_range(0, 9);
      wr = 1'($urandom_range(0, 1));
      run_cmd(wr, AW'($urandom_range(0, 15)), $urandom,
              (m < 5) ? 0 : (m == 5) ? 1 : (m == 6) ? 4 : (m < 9) ? 2 : 3,
              $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        rw_halt = 1'b1; #1;
        chk("idle_halt_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rw_halt = 1'b0;
        @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    chk("all_responses_seen", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
